// File: rtl/counter_pkg.sv
// Shared types and step arithmetic for bound_counter.
// Holds end-of-range modes, FSM states and next_count().
package counter_pkg;

  localparam int MAXW = 32;

  typedef enum logic [1:0] {
    WRAP    = 2'b00,
    SAT     = 2'b01,
    ONESHOT = 2'b10,
    RSVD    = 2'b11
  } mode_t;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  typedef struct packed {
    logic            ev;
    logic [MAXW-1:0] val;
  } nc_t;

  // One step from count; ev flags a boundary event.
  // Arithmetic carries one extra bit so the up
  // carry and the down borrow are both visible.
  function automatic nc_t next_count(
    input logic [MAXW-1:0] count,
    input logic [MAXW-1:0] step,
    input logic            up,
    input logic [MAXW-1:0] lo,
    input logic [MAXW-1:0] hi,
    input mode_t           mode
  );
    nc_t         r;
    logic [MAXW:0] cand;
    logic          brw;
    if (up) cand = {1'b0, count} + {1'b0, step};
    else    cand = {1'b0, count} - {1'b0, step};
    brw = ~up & cand[MAXW];
    if (step == '0)
      r.ev = 1'b0;
    else if (up)
      r.ev = cand > {1'b0, hi};
    else
      r.ev = brw | (cand < {1'b0, lo});
    if (!r.ev)
      r.val = cand[MAXW-1:0];
    else if (mode == WRAP)
      r.val = up ? lo : hi;
    else
      r.val = up ? hi : lo;
    return r;
  endfunction

endpackage

// File: rtl/bound_counter.sv
// Up/down counter with programmable bounds/step, wrap/sat/one-shot.
// Ports: clk, clr_n, en, up, ld, D, lo, hi, step, mode -> count, rco, tc, ovf, done.
module bound_counter
  import counter_pkg::*;
#(
  parameter int N      = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              en,
  input  logic              up,
  input  logic              ld,
  input  logic [N-1:0]      D,
  input  logic [N-1:0]      lo,
  input  logic [N-1:0]      hi,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  output logic [N-1:0]      count,
  output logic              rco,
  output logic              tc,
  output logic              ovf,
  output logic              done
);

  state_t      st;
  mode_t       md;
  nc_t         nc;
  logic [N-1:0] ld_val;
  logic         cfg_ok;
  logic         unused_hi_bits;

  assign md     = mode_t'(mode);
  assign cfg_ok = lo <= hi;

  // With lo>hi the first test already fails for
  // D>=lo, so those loads fall through to hi.
  assign ld_val = (D < lo) ? lo :
                  (D > hi) ? hi : D;

  assign nc = next_count(
    MAXW'(count), MAXW'(step), up,
    MAXW'(lo), MAXW'(hi), md
  );

  // No-event results are bounded by hi, so the
  // upper bits of the wide result are always 0.
  assign unused_hi_bits = |nc.val[MAXW-1:N];

  assign rco  = (up & (count == hi)) |
                (~up & (count == lo));
  assign done = (st == DONE);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      st    <= RUN;
    end else if (ld) begin
      count <= ld_val;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      st    <= RUN;
    end else if (en && st == RUN && cfg_ok) begin
      count <= nc.val[N-1:0];
      tc    <= nc.ev;
      if (nc.ev)
        ovf <= 1'b1;
      if (nc.ev && md == ONESHOT)
        st <= DONE;
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: doc/bound_counter.md
# bound_counter

Parametrised up/down counter with programmable bounds and step, three end-of-range modes (wrap, saturate, one-shot), synchronous load, registered terminal-count pulse and sticky overflow flag. It is the generalised successor of the team's n-bit up/down counter. It drives display refresh, scan and timeout sequencing in the panel datapath wherever a fixed 0..2^N-1 range is not sufficient.

## Interface
- N, 8, count/bound/load width
- STEP_W, 4, width of step input
- clk  in  1  system clock, all state changes on rising edge
- clr_n  in  1  synchronous active-low reset
- en  in  1  count enable; one step per enabled edge
- up  in  1  1 = count up, 0 = count down
- ld  in  1  synchronous load of D, clamped to bounds
- D  in  N  load value
- lo  in  N  lower bound, inclusive
- hi  in  N  upper bound, inclusive
- step  in  STEP_W  increment/decrement magnitude
- mode  in  2  00 WRAP, 01 SAT, 10 ONESHOT, 11 treated as SAT
- count  out  N  current value
- rco  out  1  combinational: (up & count==hi) | (~up & count==lo)
- tc  out  1  registered one-cycle boundary-event pulse
- ovf  out  1  sticky boundary-event flag
- done  out  1  high while in ONESHOT terminal state

## Operation
- Priority per edge: clr_n low > ld > (en & ~done & lo<=hi) > hold.
- Reset (clr_n=0): count=0, tc=0, ovf=0, done=0, state RUN. Reset mid-count overrides everything on that edge.
- ld: count = D<lo ? lo : (D>hi ? hi : D); done=0, ovf=0, tc=0, state RUN. ld has no effect on en.
- Step arithmetic is done in N+1 bits. The up candidate is count+step. The down candidate is count-step, with borrow detection.
- Boundary event: the up candidate is >hi, or the down candidate is <lo, or the down subtraction borrows.
- No event: count = candidate.
- Event in WRAP: count reloads to the opposite bound (lo going up, hi going down). The remainder is discarded.
- Event in SAT: count = hi going up, lo going down.
- Event in ONESHOT: count = hi or lo as in SAT; state goes to DONE and done=1. Further en is ignored until ld or reset.
- Every event sets tc=1 for the following cycle and sets ovf=1. ovf stays set until ld or reset.
- A step that lands exactly on hi/lo is not an event. rco then goes high; the next enabled step causes the event.
- step=0: count holds, no event.
- lo>hi (misconfigured): en is ignored, count holds, no tc. ld still clamps: D<lo gives lo, otherwise hi.
- If count lies outside [lo,hi] because the bounds changed, the next enabled step is evaluated by the same rules. An up step from above hi is an event.
- FSM: RUN → DONE on an ONESHOT event. DONE → RUN on ld or reset. Changing mode does not leave DONE.

## Timing
- count, tc, ovf and done are registered, with one-cycle latency from the sampled inputs.
- tc is high exactly one cycle, coincident with the updated count. Back-to-back events give continuous tc.
- rco is combinational from count, up, lo and hi. It has no registered delay.
- lo, hi, step, mode and up are sampled at every edge. Changes take effect at the next edge.

## Structure
- Package counter_pkg holds:
  - mode_t enum (WRAP, SAT, ONESHOT, RSVD)
  - state_t enum (RUN, DONE)
  - a function next_count(count, step, up, lo, hi, mode) returning {event, value}
- Single module; no sub-module needed.

## Test plan
- N=8, lo=10, hi=20, step=3, WRAP, up, en held from count=10 → 13,16,19, then 10 with tc pulse, ovf=1; rco never high.
- Same setup in SAT, step=5 → 15,20 (rco=1), then 20 with tc; stays 20, tc each subsequent enabled edge.
- ONESHOT, down, lo=0, hi=255, ld D=7, step=4 → 3, then 0 with tc and done=1. en ignored afterwards; ld D=50 clears done and ovf, count=50.
- ld D=5 with lo=10 gives count=10. ld D=30 with hi=20 gives 20. ld and en on the same edge: the load wins.
- Reset: clr_n low mid-run at count=17, ovf=1 → next edge count=0, tc=0, ovf=0, done=0. clr_n low with ld=1 still resets.
- Edge cases: lo=20, hi=10 with en → count holds, no tc. step=0 → holds. count=255, hi=255, step=1, up → event, no 9-bit wrap leaks into count.
